// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the five-stage pipeline and its sequencing controller.
// The pipeline side (master) drives the hazard inputs, and the controller
// (slave) returns hold/flush steering, the interrupt pulse and the counters.
interface pipe_hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             mem_rd_ex;
  logic [4:0]       rt_ex;
  logic [2:0]       pc_src_id;
  logic             branch_taken_ex;
  logic             kernel_id;
  logic             irq_req;
  logic             cnt_clr;

  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_flush;
  logic             irqout;
  logic             irq_pending;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs_id, rt_id, mem_rd_ex, rt_ex, pc_src_id, branch_taken_ex,
           kernel_id, irq_req, cnt_clr,
    input  pc_hold, ifid_hold, ifid_flush, idex_flush, irqout, irq_pending,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_id, rt_id, mem_rd_ex, rt_ex, pc_src_id, branch_taken_ex,
           kernel_id, irq_req, cnt_clr,
    output pc_hold, ifid_hold, ifid_flush, idex_flush, irqout, irq_pending,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencing controller: load-use stalls, wrong-path kills after
// jumps and taken branches, interrupt injection into decode, and saturating
// stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        reset,
  pipe_hazard_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    KWAIT = 2'd2,
    KEXIT = 2'd3
  } irq_state_t;

  irq_state_t       state_q, state_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic jump_id;
  logic pipe_clean;
  logic pc_hold;
  logic ifid_hold;
  logic ifid_flush;
  logic idex_flush;
  logic irqout;

  // Hazard detection: a load in EX feeding either source of the ID instruction ($0 never hazards).
  always_comb begin
    lu = hz.mem_rd_ex && (hz.rt_ex != 5'd0) &&
         ((hz.rt_ex == hz.rs_id) || (hz.rt_ex == hz.rt_id));
    jump_id = (hz.pc_src_id >= 3'd2) && (hz.pc_src_id <= 3'd5);
    pipe_clean = !hz.branch_taken_ex && !lu && (hz.pc_src_id == 3'd0) && !hz.kernel_id;
  end

  // Prioritised hold/flush steering: taken branch, then load-use, then jump/exception.
  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (hz.branch_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
    end else if (jump_id) begin
      ifid_flush = 1'b1;
    end
  end

  // Interrupt FSM next state; a branch during ARM kills the injection and keeps it pending for retry.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    irqout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.irq_req) begin
          pending_d = 1'b1;
        end
        if (pending_q && pipe_clean) begin
          state_d = ARM;
        end
      end
      ARM: begin
        irqout = 1'b1;
        if (hz.branch_taken_ex) begin
          state_d = IDLE;
        end else begin
          pending_d = 1'b0;
          state_d   = KWAIT;
        end
      end
      KWAIT: begin
        if (hz.kernel_id) begin
          state_d = KEXIT;
        end
      end
      KEXIT: begin
        if (!hz.kernel_id) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating counters; a clear wins over any increment in the same cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (lu && !hz.branch_taken_ex && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if ((ifid_flush || idex_flush) && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // State, pending latch and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_hold     = pc_hold;
  assign hz.ifid_hold   = ifid_hold;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.irqout      = irqout;
  assign hz.irq_pending = pending_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural model of the controller rules.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  pipe_hazard_if #(.CNT_W(CNT_W)) hz();

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: pending flag, injection-in-progress flags, counters.
  bit m_pending;
  bit m_arm;
  bit m_wait_k;
  bit m_wait_exit;
  int m_stall;
  int m_flush;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelLoadUse();
    return hz.mem_rd_ex && (hz.rt_ex != 5'd0) &&
           ((hz.rt_ex == hz.rs_id) || (hz.rt_ex == hz.rt_id));
  endfunction

  function automatic bit modelJump();
    int s;
    s = int'(hz.pc_src_id);
    return (s >= 2) && (s <= 5);
  endfunction

  task automatic resetModel();
    m_pending   = 1'b0;
    m_arm       = 1'b0;
    m_wait_k    = 1'b0;
    m_wait_exit = 1'b0;
    m_stall     = 0;
    m_flush     = 0;
  endtask

  task automatic applyStimulus(input bit mem_rd, input int rt_ex, input int rs, input int rt,
                               input int pc_src, input bit br, input bit kernel,
                               input bit irq, input bit clr);
    hz.mem_rd_ex       = mem_rd;
    hz.rt_ex           = 5'(rt_ex);
    hz.rs_id           = 5'(rs);
    hz.rt_id           = 5'(rt);
    hz.pc_src_id       = 3'(pc_src);
    hz.branch_taken_ex = br;
    hz.kernel_id       = kernel;
    hz.irq_req         = irq;
    hz.cnt_clr         = clr;
  endtask

  task automatic checkOutput();
    bit lu;
    bit br;
    lu = modelLoadUse();
    br = hz.branch_taken_ex;
    checkValue("pc_hold",     32'(hz.pc_hold),     32'(!br && lu));
    checkValue("ifid_hold",   32'(hz.ifid_hold),   32'(!br && lu));
    checkValue("idex_flush",  32'(hz.idex_flush),  32'(br || lu));
    checkValue("ifid_flush",  32'(hz.ifid_flush),  32'(br || (!lu && modelJump())));
    checkValue("irqout",      32'(hz.irqout),      32'(m_arm));
    checkValue("irq_pending", 32'(hz.irq_pending), 32'(m_pending));
    checkValue("stall_cnt",   32'(hz.stall_cnt),   32'(m_stall));
    checkValue("flush_cnt",   32'(hz.flush_cnt),   32'(m_flush));
  endtask

  // Advance the model by one rising edge using the inputs held during the cycle.
  task automatic advanceModel();
    bit lu, br, fl, clean, idle, arm_next;
    lu    = modelLoadUse();
    br    = hz.branch_taken_ex;
    fl    = br || lu || modelJump();
    clean = !br && !lu && (hz.pc_src_id == 3'd0) && !hz.kernel_id;
    idle  = !(m_arm || m_wait_k || m_wait_exit);
    if (idle) begin
      arm_next = m_pending && clean;
      if (hz.irq_req) m_pending = 1'b1;
      m_arm = arm_next;
    end else if (m_arm) begin
      m_arm = 1'b0;
      if (!br) begin
        m_pending = 1'b0;
        m_wait_k  = 1'b1;
      end
    end else if (m_wait_k) begin
      if (hz.kernel_id) begin
        m_wait_k    = 1'b0;
        m_wait_exit = 1'b1;
      end
    end else begin
      if (!hz.kernel_id) m_wait_exit = 1'b0;
    end
    if (hz.cnt_clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (lu && !br && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
    end
  endtask

  task automatic runCycle();
    #1;
    checkOutput();
    @(posedge clk);
    advanceModel();
    @(negedge clk);
  endtask

  task automatic idleCycle(input bit kernel);
    applyStimulus(0, 0, 0, 0, 0, 0, kernel, 0, 0);
    runCycle();
  endtask

  initial begin
    // Reset state
    resetModel();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkValue("rst_irqout",    32'(hz.irqout),      32'd0);
    checkValue("rst_pending",   32'(hz.irq_pending), 32'd0);
    checkValue("rst_stall_cnt", 32'(hz.stall_cnt),   32'd0);
    checkValue("rst_flush_cnt", 32'(hz.flush_cnt),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Load-use on rs for a single cycle
    applyStimulus(1, 8, 8, 0, 0, 0, 0, 0, 0);
    #1;
    checkValue("lu_pc_hold",    32'(hz.pc_hold),    32'd1);
    checkValue("lu_idex_flush", 32'(hz.idex_flush), 32'd1);
    runCycle();

    // Load into $0 never hazards
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkValue("lu_stall_cnt",  32'(hz.stall_cnt), 32'd1);
    checkValue("zero_pc_hold",  32'(hz.pc_hold),   32'd0);
    checkValue("zero_idex",     32'(hz.idex_flush),32'd0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkValue("zero_stall_cnt", 32'(hz.stall_cnt), 32'd1);
    runCycle();

    // Taken branch overrides load-use
    applyStimulus(1, 8, 0, 8, 0, 1, 0, 0, 0);
    #1;
    checkValue("br_pc_hold",    32'(hz.pc_hold),    32'd0);
    checkValue("br_ifid_flush", 32'(hz.ifid_flush), 32'd1);
    checkValue("br_idex_flush", 32'(hz.idex_flush), 32'd1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 2, 0, 0, 0, 0);
    #1;
    checkValue("br_stall_cnt",  32'(hz.stall_cnt),  32'd1);
    checkValue("br_flush_cnt",  32'(hz.flush_cnt),  32'd2);
    checkValue("j_ifid_flush",  32'(hz.ifid_flush), 32'd1);
    runCycle();

    // Interrupt on a clean pipeline, then a second one after kernel exit
    for (int n = 0; n < 2; n++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      runCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkValue("irq_pending_rise", 32'(hz.irq_pending), 32'd1);
      checkValue("irq_early",        32'(hz.irqout),      32'd0);
      runCycle();
      #1;
      checkValue("irq_pulse",        32'(hz.irqout),      32'd1);
      runCycle();
      #1;
      checkValue("irq_pulse_end",    32'(hz.irqout),      32'd0);
      checkValue("irq_pending_clr",  32'(hz.irq_pending), 32'd0);
      runCycle();
      idleCycle(1);
      idleCycle(0);
    end

    // Injection killed by a branch in ARM, then retried
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    runCycle();
    idleCycle(0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    checkValue("kill_arm_pulse", 32'(hz.irqout), 32'd1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkValue("kill_pending",   32'(hz.irq_pending), 32'd1);
    checkValue("kill_no_pulse",  32'(hz.irqout),      32'd0);
    runCycle();
    #1;
    checkValue("retry_pulse",    32'(hz.irqout),      32'd1);
    runCycle();
    idleCycle(1);
    idleCycle(0);

    // Asynchronous reset in the middle of ARM
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    runCycle();
    idleCycle(0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkValue("pre_rst_pulse", 32'(hz.irqout), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkValue("rst_arm_irqout",  32'(hz.irqout),      32'd0);
    checkValue("rst_arm_pending", 32'(hz.irq_pending), 32'd0);
    resetModel();
    reset = 1'b0;
    @(posedge clk);
    advanceModel();
    @(negedge clk);

    // Saturation of both counters under sustained load-use, then clear with an event
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 5, 3, 5, 0, 0, 0, 0, 0);
      runCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkValue("sat_stall_cnt", 32'(hz.stall_cnt), 32'(CMAX));
    checkValue("sat_flush_cnt", 32'(hz.flush_cnt), 32'(CMAX));
    runCycle();
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 0, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkValue("clr_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    checkValue("clr_flush_cnt", 32'(hz.flush_cnt), 32'd0);
    runCycle();

    // Random traffic against the model
    begin
      bit kern;
      kern = 1'b0;
      for (int i = 0; i < 600; i++) begin
        int psel;
        psel = int'($urandom_range(0, 9));
        if ($urandom_range(0, 99) < 15) kern = ~kern;
        applyStimulus(($urandom_range(0, 99) < 25),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)),
                      (psel < 7) ? 0 : int'($urandom_range(1, 7)),
                      ($urandom_range(0, 99) < 10),
                      kern,
                      ($urandom_range(0, 99) < 20),
                      ($urandom_range(0, 99) < 3));
        runCycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
